// File: rtl/rocket_dmem_req_driver_if.sv
// Core-to-dcache request/response bundle plus the command and report channels of the dmem request driver.
// master = driver side, slave = harness side.
interface rocket_dmem_req_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [39:0] cmd_addr;
  logic [2:0]  cmd_typ;
  logic [63:0] cmd_data;
  logic [7:0]  cmd_mask;

  logic        io_dmem_req_ready;
  logic        io_dmem_req_valid;
  logic [39:0] io_dmem_req_bits_addr;
  logic [6:0]  io_dmem_req_bits_tag;
  logic [4:0]  io_dmem_req_bits_cmd;
  logic [2:0]  io_dmem_req_bits_typ;
  logic        io_dmem_req_bits_phys;
  logic        io_dmem_s1_kill;
  logic [63:0] io_dmem_s1_data_data;
  logic [7:0]  io_dmem_s1_data_mask;
  logic        io_dmem_s2_nack;
  logic        io_dmem_resp_valid;
  logic [6:0]  io_dmem_resp_bits_tag;
  logic [63:0] io_dmem_resp_bits_data;
  logic        io_dmem_resp_bits_has_data;

  logic        st_done_valid;
  logic [6:0]  st_done_tag;
  logic        ld_resp_valid;
  logic [6:0]  ld_resp_tag;
  logic [63:0] ld_resp_data;
  logic [3:0]  outstanding;
  logic        err;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_typ, cmd_data, cmd_mask,
           io_dmem_req_ready, io_dmem_s2_nack, io_dmem_resp_valid,
           io_dmem_resp_bits_tag, io_dmem_resp_bits_data, io_dmem_resp_bits_has_data,
    output cmd_ready, io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_tag,
           io_dmem_req_bits_cmd, io_dmem_req_bits_typ, io_dmem_req_bits_phys,
           io_dmem_s1_kill, io_dmem_s1_data_data, io_dmem_s1_data_mask,
           st_done_valid, st_done_tag, ld_resp_valid, ld_resp_tag, ld_resp_data,
           outstanding, err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_typ, cmd_data, cmd_mask,
           io_dmem_req_ready, io_dmem_s2_nack, io_dmem_resp_valid,
           io_dmem_resp_bits_tag, io_dmem_resp_bits_data, io_dmem_resp_bits_has_data,
    input  cmd_ready, io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_tag,
           io_dmem_req_bits_cmd, io_dmem_req_bits_typ, io_dmem_req_bits_phys,
           io_dmem_s1_kill, io_dmem_s1_data_data, io_dmem_s1_data_mask,
           st_done_valid, st_done_tag, ld_resp_valid, ld_resp_tag, ld_resp_data,
           outstanding, err
  );
endinterface

// File: rtl/rocket_dmem_req_driver.sv
// Harness master for the core dmem port: tag allocation, s1 store data, s2-nack replay,
// and store-done / load-response reporting.
module rocket_dmem_req_driver #(
  parameter int unsigned NUM_TAGS     = 8,
  parameter int unsigned REPLAY_DEPTH = 4
) (
  input logic                      clock,
  input logic                      reset,
  rocket_dmem_req_driver_if.master bus
);
  localparam int unsigned TAG_W  = 7;
  localparam int unsigned TIDX_W = $clog2(NUM_TAGS);
  localparam int unsigned RPTR_W = $clog2(REPLAY_DEPTH);
  localparam int unsigned CNT_W  = $clog2(REPLAY_DEPTH + 1);
  localparam int unsigned OUT_W  = 4;

  typedef struct packed {
    logic             write;
    logic [39:0]      addr;
    logic [2:0]       typ;
    logic [63:0]      data;
    logic [7:0]       mask;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t               s0_req, s1_q, s2_q;
  logic               s1_valid, s2_valid;
  req_t               fifo_q [REPLAY_DEPTH];
  logic [RPTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [NUM_TAGS-1:0] alloc_q, alloc_d, is_store_q;
  logic [TIDX_W-1:0]  free_idx;
  logic               free_any;
  logic [OUT_W-1:0]   out_d, out_q;

  logic               fifo_empty, fifo_full, issue_open, req_valid_c, fire;
  logic               new_fire, replay_fire, nack_push, push_ok, overflow;
  logic               st_done_c, resp_hit, resp_ok, resp_bad;
  logic [TIDX_W-1:0]  resp_idx, s2_idx;

  logic               st_done_valid_q, ld_resp_valid_q, err_q;
  logic [TAG_W-1:0]   st_done_tag_q, ld_resp_tag_q;
  logic [63:0]        ld_resp_data_q;

  // Lowest-index free tag
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_any = 1'b1;
        free_idx = TIDX_W'(i);
      end
    end
  end

  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == CNT_W'(REPLAY_DEPTH));
  assign issue_open  = !reset && fifo_empty && free_any;
  assign req_valid_c = !reset && (!fifo_empty || (bus.cmd_valid && issue_open));
  assign fire        = req_valid_c && bus.io_dmem_req_ready;
  assign new_fire    = fire && fifo_empty;
  assign replay_fire = fire && !fifo_empty;

  // s0 source: replay head wins over a fresh command
  always_comb begin
    s0_req = '0;
    if (!fifo_empty) begin
      s0_req = fifo_q[rd_ptr];
    end else begin
      s0_req.write = bus.cmd_write;
      s0_req.addr  = bus.cmd_addr;
      s0_req.typ   = bus.cmd_typ;
      s0_req.data  = bus.cmd_write ? bus.cmd_data : 64'h0;
      s0_req.mask  = bus.cmd_write ? bus.cmd_mask : 8'h0;
      s0_req.tag   = TAG_W'(free_idx);
    end
  end

  assign s2_idx    = s2_q.tag[TIDX_W-1:0];
  assign nack_push = s2_valid && bus.io_dmem_s2_nack;
  assign push_ok   = nack_push && !fifo_full;
  assign overflow  = nack_push && fifo_full;
  assign st_done_c = s2_valid && s2_q.write && !bus.io_dmem_s2_nack;

  assign resp_idx  = bus.io_dmem_resp_bits_tag[TIDX_W-1:0];
  assign resp_hit  = bus.io_dmem_resp_valid && bus.io_dmem_resp_bits_has_data;
  assign resp_ok   = resp_hit && (bus.io_dmem_resp_bits_tag < TAG_W'(NUM_TAGS))
                     && alloc_q[resp_idx] && !is_store_q[resp_idx];
  assign resp_bad  = resp_hit && !resp_ok;

  // Next allocation vector and its population count
  always_comb begin
    alloc_d = alloc_q;
    if (new_fire)  alloc_d[free_idx] = 1'b1;
    if (st_done_c) alloc_d[s2_idx]   = 1'b0;
    if (resp_ok)   alloc_d[resp_idx] = 1'b0;
    out_d = '0;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      out_d = out_d + OUT_W'(alloc_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q            <= '0;
      s2_q            <= '0;
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      fifo_cnt        <= '0;
      alloc_q         <= '0;
      is_store_q      <= '0;
      out_q           <= '0;
      err_q           <= 1'b0;
      st_done_valid_q <= 1'b0;
      st_done_tag_q   <= '0;
      ld_resp_valid_q <= 1'b0;
      ld_resp_tag_q   <= '0;
      ld_resp_data_q  <= '0;
      for (int i = 0; i < int'(REPLAY_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      s1_valid <= fire;
      s1_q     <= fire ? s0_req : '0;
      s2_valid <= s1_valid;
      s2_q     <= s1_q;

      if (push_ok) begin
        fifo_q[wr_ptr] <= s2_q;
        wr_ptr         <= wr_ptr + RPTR_W'(1);
      end
      if (replay_fire) rd_ptr <= rd_ptr + RPTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push_ok) - CNT_W'(replay_fire);

      alloc_q <= alloc_d;
      out_q   <= out_d;
      if (new_fire) is_store_q[free_idx] <= bus.cmd_write;

      err_q <= err_q || resp_bad || overflow;

      st_done_valid_q <= st_done_c;
      st_done_tag_q   <= st_done_c ? s2_q.tag : '0;
      ld_resp_valid_q <= resp_ok;
      ld_resp_tag_q   <= resp_ok ? bus.io_dmem_resp_bits_tag : '0;
      ld_resp_data_q  <= resp_ok ? bus.io_dmem_resp_bits_data : 64'h0;
    end
  end

  assign bus.cmd_ready             = issue_open && bus.io_dmem_req_ready;
  assign bus.io_dmem_req_valid     = req_valid_c;
  assign bus.io_dmem_req_bits_addr = req_valid_c ? s0_req.addr : 40'h0;
  assign bus.io_dmem_req_bits_tag  = req_valid_c ? s0_req.tag : '0;
  assign bus.io_dmem_req_bits_cmd  = (req_valid_c && s0_req.write) ? 5'h01 : 5'h00;
  assign bus.io_dmem_req_bits_typ  = req_valid_c ? s0_req.typ : 3'h0;
  assign bus.io_dmem_req_bits_phys = 1'b0;
  assign bus.io_dmem_s1_kill       = 1'b0;
  assign bus.io_dmem_s1_data_data  = (!reset && s1_valid) ? s1_q.data : 64'h0;
  assign bus.io_dmem_s1_data_mask  = (!reset && s1_valid) ? s1_q.mask : 8'h0;

  assign bus.st_done_valid = st_done_valid_q;
  assign bus.st_done_tag   = st_done_tag_q;
  assign bus.ld_resp_valid = ld_resp_valid_q;
  assign bus.ld_resp_tag   = ld_resp_tag_q;
  assign bus.ld_resp_data  = ld_resp_data_q;
  assign bus.outstanding   = out_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_rocket_dmem_req_driver.sv
// Directed bench for rocket_dmem_req_driver: load, store, nack replay, tag exhaustion,
// stray response and mid-operation reset.
module tb_rocket_dmem_req_driver;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  rocket_dmem_req_driver_if bus ();

  rocket_dmem_req_driver dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_cmd(input logic v, input logic wr, input logic [39:0] addr,
                         input logic [63:0] data, input logic [7:0] mask);
    bus.cmd_valid = v;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_typ   = 3'h3;
    bus.cmd_data  = data;
    bus.cmd_mask  = mask;
  endtask

  task automatic set_resp(input logic v, input logic hd, input logic [6:0] tag,
                          input logic [63:0] data);
    bus.io_dmem_resp_valid         = v;
    bus.io_dmem_resp_bits_has_data = hd;
    bus.io_dmem_resp_bits_tag      = tag;
    bus.io_dmem_resp_bits_data     = data;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    set_cmd(1'b1, 1'b0, 40'h0, 64'h0, 8'h0);
    set_resp(1'b0, 1'b0, 7'h0, 64'h0);
    bus.io_dmem_req_ready = 1'b1;
    bus.io_dmem_s2_nack   = 1'b0;
    tick();
    tick();

    // Reset state, with a command offered and the cache ready
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    chk("rst_req_valid", 64'(bus.io_dmem_req_valid), 64'h0);
    chk("rst_outstanding", 64'(bus.outstanding), 64'h0);
    chk("rst_err", 64'(bus.err), 64'h0);
    rst = 1'b0;
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    tick();

    // Single load
    set_cmd(1'b1, 1'b0, 40'h80001000, 64'h0, 8'h0);
    #1;
    chk("ld_req_valid", 64'(bus.io_dmem_req_valid), 64'h1);
    chk("ld_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    chk("ld_req_tag", 64'(bus.io_dmem_req_bits_tag), 64'h0);
    chk("ld_req_cmd", 64'(bus.io_dmem_req_bits_cmd), 64'h0);
    chk("ld_req_addr", 64'(bus.io_dmem_req_bits_addr), 64'h80001000);
    tick();
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    chk("ld_outstanding1", 64'(bus.outstanding), 64'h1);
    chk("ld_s1_mask", 64'(bus.io_dmem_s1_data_mask), 64'h0);
    tick();
    tick();
    set_resp(1'b1, 1'b1, 7'h0, 64'hDEADBEEF_CAFEF00D);
    tick();
    set_resp(1'b0, 1'b0, 7'h0, 64'h0);
    chk("ld_resp_valid", 64'(bus.ld_resp_valid), 64'h1);
    chk("ld_resp_tag", 64'(bus.ld_resp_tag), 64'h0);
    chk("ld_resp_data", bus.ld_resp_data, 64'hDEADBEEF_CAFEF00D);
    chk("ld_outstanding0", 64'(bus.outstanding), 64'h0);
    tick();
    chk("ld_resp_pulse", 64'(bus.ld_resp_valid), 64'h0);

    // Single store
    set_cmd(1'b1, 1'b1, 40'h80002000, 64'h1122334455667788, 8'hFF);
    #1;
    chk("st_req_tag", 64'(bus.io_dmem_req_bits_tag), 64'h0);
    chk("st_req_cmd", 64'(bus.io_dmem_req_bits_cmd), 64'h1);
    tick();
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    chk("st_s1_data", bus.io_dmem_s1_data_data, 64'h1122334455667788);
    chk("st_s1_mask", 64'(bus.io_dmem_s1_data_mask), 64'hFF);
    tick();
    chk("st_s1_idle", bus.io_dmem_s1_data_data, 64'h0);
    chk("st_done_early", 64'(bus.st_done_valid), 64'h0);
    tick();
    chk("st_done_valid", 64'(bus.st_done_valid), 64'h1);
    chk("st_done_tag", 64'(bus.st_done_tag), 64'h0);
    chk("st_outstanding", 64'(bus.outstanding), 64'h0);
    tick();

    // Nack replay: store nacked in s2, replayed ahead of a waiting load
    set_cmd(1'b1, 1'b1, 40'h80003000, 64'hA5A5A5A5_5A5A5A5A, 8'h0F);
    tick();
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    tick();
    bus.io_dmem_s2_nack = 1'b1;
    tick();
    bus.io_dmem_s2_nack = 1'b0;
    set_cmd(1'b1, 1'b0, 40'h80004000, 64'h0, 8'h0);
    #1;
    chk("nk_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    chk("nk_req_valid", 64'(bus.io_dmem_req_valid), 64'h1);
    chk("nk_req_tag", 64'(bus.io_dmem_req_bits_tag), 64'h0);
    chk("nk_req_addr", 64'(bus.io_dmem_req_bits_addr), 64'h80003000);
    chk("nk_req_cmd", 64'(bus.io_dmem_req_bits_cmd), 64'h1);
    chk("nk_no_done", 64'(bus.st_done_valid), 64'h0);
    tick();
    chk("nk_s1_data", bus.io_dmem_s1_data_data, 64'hA5A5A5A5_5A5A5A5A);
    chk("nk_new_ready", 64'(bus.cmd_ready), 64'h1);
    chk("nk_new_tag", 64'(bus.io_dmem_req_bits_tag), 64'h1);
    chk("nk_new_addr", 64'(bus.io_dmem_req_bits_addr), 64'h80004000);
    tick();
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    tick();
    chk("nk_done_valid", 64'(bus.st_done_valid), 64'h1);
    chk("nk_done_tag", 64'(bus.st_done_tag), 64'h0);
    chk("nk_outstanding", 64'(bus.outstanding), 64'h1);
    set_resp(1'b1, 1'b1, 7'h1, 64'h0123456789ABCDEF);
    tick();
    set_resp(1'b0, 1'b0, 7'h0, 64'h0);
    chk("nk_ld_tag", 64'(bus.ld_resp_tag), 64'h1);
    chk("nk_ld_data", bus.ld_resp_data, 64'h0123456789ABCDEF);
    chk("nk_outstanding0", 64'(bus.outstanding), 64'h0);

    // Tag exhaustion
    for (int i = 0; i < 8; i++) begin
      set_cmd(1'b1, 1'b0, 40'h1000 + 40'(i * 8), 64'h0, 8'h0);
      #1;
      chk($sformatf("ex_tag%0d", i), 64'(bus.io_dmem_req_bits_tag), 64'(i));
      tick();
    end
    chk("ex_outstanding8", 64'(bus.outstanding), 64'h8);
    chk("ex_cmd_ready", 64'(bus.cmd_ready), 64'h0);
    chk("ex_req_valid", 64'(bus.io_dmem_req_valid), 64'h0);
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    set_resp(1'b1, 1'b1, 7'h3, 64'h3333);
    tick();
    set_resp(1'b0, 1'b0, 7'h0, 64'h0);
    chk("ex_ld_tag3", 64'(bus.ld_resp_tag), 64'h3);
    chk("ex_outstanding7", 64'(bus.outstanding), 64'h7);
    set_cmd(1'b1, 1'b0, 40'h2000, 64'h0, 8'h0);
    #1;
    chk("ex_reuse_ready", 64'(bus.cmd_ready), 64'h1);
    chk("ex_reuse_tag", 64'(bus.io_dmem_req_bits_tag), 64'h3);
    tick();
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    chk("ex_outstanding8b", 64'(bus.outstanding), 64'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ex_rst_outstanding", 64'(bus.outstanding), 64'h0);
    tick();

    // Stray responses: has_data=0 ignored, unallocated tag flags err
    set_resp(1'b1, 1'b0, 7'h5, 64'h55);
    tick();
    chk("sr_nodata_err", 64'(bus.err), 64'h0);
    set_resp(1'b1, 1'b1, 7'h5, 64'h55);
    tick();
    set_resp(1'b0, 1'b0, 7'h0, 64'h0);
    chk("sr_err", 64'(bus.err), 64'h1);
    chk("sr_no_ld_resp", 64'(bus.ld_resp_valid), 64'h0);
    tick();
    tick();
    chk("sr_err_sticky", 64'(bus.err), 64'h1);

    // Reset with three stores in flight
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 1'b1, 40'h3000 + 40'(i * 8), 64'h77 + 64'(i), 8'hFF);
      tick();
    end
    set_cmd(1'b1, 1'b1, 40'h4000, 64'h99, 8'hFF);
    rst = 1'b1;
    #1;
    chk("rm_req_valid_in_rst", 64'(bus.io_dmem_req_valid), 64'h0);
    tick();
    rst = 1'b0;
    set_cmd(1'b0, 1'b0, 40'h0, 64'h0, 8'h0);
    chk("rm_outstanding", 64'(bus.outstanding), 64'h0);
    chk("rm_err", 64'(bus.err), 64'h0);
    chk("rm_req_valid", 64'(bus.io_dmem_req_valid), 64'h0);
    chk("rm_st_done0", 64'(bus.st_done_valid), 64'h0);
    tick();
    chk("rm_st_done1", 64'(bus.st_done_valid), 64'h0);
    chk("rm_ld_resp1", 64'(bus.ld_resp_valid), 64'h0);
    tick();
    chk("rm_st_done2", 64'(bus.st_done_valid), 64'h0);
    chk("rm_outstanding2", 64'(bus.outstanding), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
